// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision float constants and converter state encodings
package fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } fp_state_t;

endpackage

// File: rtl/fp_pack.sv
// rtl/fp_pack.sv - assembles {sign, exp, frac} from a normalised mantissa and exponent
//
// Ports:
//   mant      in  INT_W  normalised mantissa, leading one in mant[INT_W-1]
//   exponent  in  8      biased exponent
//   fp        out 32     {1'b0, exponent, fraction left-aligned into 23 bits}
module fp_pack
    import fp_pkg::*;
#(
    parameter int INT_W = 8
) (
    input  logic [INT_W-1:0]    mant,
    input  logic [FP_EXP_W-1:0] exponent,
    output logic [31:0]         fp
);

    logic [FP_FRAC_W-1:0] frac;

    // The hidden leading one is dropped; the remaining INT_W-1 bits are pushed
    // up against the top of the fraction field, zero-filling below.
    always_comb begin
        frac = FP_FRAC_W'(mant[INT_W-2:0]) << (FP_FRAC_W + 1 - INT_W);
        fp   = {1'b0, exponent, frac};
    end

endmodule

// File: rtl/int_to_fp_seq.sv
// rtl/int_to_fp_seq.sv - sequential unsigned integer to single-precision float converter
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      in_int is valid
//   in_ready   out 1      block can accept (idle)
//   in_int     in  INT_W  unsigned integer operand
//   out_valid  out 1      out_fp is valid
//   out_ready  in  1      downstream accepts out_fp
//   out_fp     out 32     {sign, exp[7:0], frac[22:0]}
//   busy       out 1      conversion or result pending
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_fp,
    output logic             busy
);

    // Widths above 24 would need rounding; below 2 there is no fraction field.
    if (INT_W < 2 || INT_W > 24) begin : g_bad_int_w
        $error("int_to_fp_seq: INT_W must be in 2..24");
    end

    // Exponent of an operand whose leading one already sits in the MSB.
    localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_BIAS + INT_W - 1);

    fp_state_t            state, state_next;
    logic [INT_W-1:0]     mant, mant_next;
    logic [FP_EXP_W-1:0]  exponent, exponent_next;
    logic [31:0]          fp_q, fp_next;
    logic [31:0]          packed_fp;

    fp_pack #(.INT_W(INT_W)) u_pack (
        .mant     (mant),
        .exponent (exponent),
        .fp       (packed_fp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mant     <= '0;
            exponent <= '0;
            fp_q     <= '0;
        end else begin
            state    <= state_next;
            mant     <= mant_next;
            exponent <= exponent_next;
            fp_q     <= fp_next;
        end
    end

    always_comb begin
        state_next    = state;
        mant_next     = mant;
        exponent_next = exponent;
        fp_next       = fp_q;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_next     = in_int;
                    exponent_next = EXP_INIT;
                    // Zero has no leading one; skip normalisation entirely.
                    if (in_int == '0) begin
                        fp_next    = '0;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (mant[INT_W-1]) begin
                    fp_next    = packed_fp;
                    state_next = ST_DONE;
                end else begin
                    mant_next     = mant << 1;
                    exponent_next = exponent - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_fp    = fp_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// tb/tb_int_to_fp_seq.sv - self-checking bench for int_to_fp_seq
module tb_int_to_fp_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        busy;

    int n_cmp;
    int n_bad;

    int_to_fp_seq #(.INT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  val;
        logic [31:0] fp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: locate the leading one directly and place the value into the float fields.
    function automatic logic [31:0] model(input logic [7:0] v);
        int p;
        logic [31:0] w;
        if (v == 8'd0) return 32'h0;
        p = 0;
        for (int i = 0; i < 8; i++) if (v[i]) p = i;
        w = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), w[22:0]};
    endfunction

    // Float back to integer, as the downstream fp_to_int stage would do for these values.
    function automatic int decode(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]);
        m = {8'h0, 1'b1, f[22:0]};
        return int'(m >> (150 - e));
    endfunction

    // Accept one operand, wait for the result, optionally stall, then hand it off.
    task automatic convert(input logic [7:0] v, input int stall, output logic [31:0] fp, output int lat);
        logic [31:0] held;
        in_int   = v;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_int   = ~v;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        fp   = out_fp;
        held = out_fp;
        for (int s = 0; s < stall; s++) begin
            step();
            check("stall_fp_stable", out_fp, held);
            check("stall_valid_high", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drops_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] fp;
        logic [31:0] held;
        int lat;
        int cnt;
        logic [7:0] v;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_int = 8'd77;
        out_ready = 1'b0;

        vecs[0] = '{8'd255, 32'h437F0000, 2};
        vecs[1] = '{8'd1,   32'h3F800000, 9};
        vecs[2] = '{8'd0,   32'h00000000, 1};
        vecs[3] = '{8'd111, 32'h42DE0000, 3};
        vecs[4] = '{8'd64,  32'h42800000, 3};
        vecs[5] = '{8'd102, 32'h42CC0000, 3};
        vecs[6] = '{8'd2,   32'h40000000, 8};
        vecs[7] = '{8'd128, 32'h43000000, 2};
        vecs[8] = '{8'd3,   32'h40400000, 8};
        vecs[9] = '{8'd5,   32'h40A00000, 7};

        step();
        step();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_fp", out_fp, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;

        // Directed table
        for (int k = 0; k < 10; k++) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            convert(vecs[k].val, k % 3, fp, lat);
            check($sformatf("fp_of_%0d", vecs[k].val), fp, vecs[k].fp);
            check($sformatf("latency_of_%0d", vecs[k].val), 32'(lat), 32'(vecs[k].lat));
            check($sformatf("roundtrip_%0d", vecs[k].val), 32'(decode(fp)), 32'(vecs[k].val));
        end

        // Back-pressure: result held for 5 cycles while a second operand waits
        in_int = 8'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        held = out_fp;
        check("bp_first_result", held, 32'h40A00000);
        in_int = 8'd7;
        in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp_fp_stable", out_fp, held);
            check("bp_valid_stable", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_after_handshake", 32'(in_ready), 32'd1);
        check("bp_valid_dropped", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(busy), 32'd1);
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check("bp_second_result", out_fp, 32'h40E00000);
        check("bp_second_latency", 32'(cnt), 32'd7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while normalising aborts the operand
        in_int = 8'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("abort_busy_in_norm", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_fp", out_fp, 32'h0);
        cnt = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (out_valid) cnt++;
        end
        check("abort_no_output", 32'(cnt), 32'd0);
        convert(8'd3, 0, fp, lat);
        check("after_abort_fp", fp, 32'h40400000);

        // Randomised back-to-back stream with stalls, checked against the reference
        for (int k = 0; k < 40; k++) begin
            v = 8'($urandom_range(0, 255));
            if (k == 0) v = 8'd0;
            if (k == 1) v = 8'd255;
            convert(v, int'($urandom_range(0, 3)), fp, lat);
            check($sformatf("rand_fp_%0d", v), fp, model(v));
            check($sformatf("rand_roundtrip_%0d", v), 32'(decode(fp)), 32'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
